// File: rtl/keypad_code_lock_if.sv
// Keypad lock bus: key/enter strobes in,
// display feed and result flags out.
interface keypad_code_lock_if #(
  parameter int DIGITS  = 4,
  parameter int N_CODES = 3
);
  localparam int BW = 4 * DIGITS;
  localparam int IW = (N_CODES > 1) ? $clog2(N_CODES) : 1;
  localparam int CW = $clog2(DIGITS + 1);

  logic          key_valid;
  logic [3:0]    key_code;
  logic          enter_valid;
  logic [BW-1:0] disp;
  logic          match;
  logic [IW-1:0] match_idx;
  logic          fail;
  logic          locked;
  logic [CW-1:0] entry_cnt;

  modport master (
    output key_valid, key_code, enter_valid,
    input  disp, match, match_idx, fail, locked, entry_cnt
  );

  modport slave (
    input  key_valid, key_code, enter_valid,
    output disp, match, match_idx, fail, locked, entry_cnt
  );
endinterface

// File: rtl/keypad_code_lock.sv
// Keypad code matcher: buffers the last DIGITS keys, compares on
// enter, holds the result, and locks out after repeated failures.
module keypad_code_lock #(
  parameter int                          DIGITS      = 4,
  parameter int                          N_CODES     = 3,
  parameter logic [N_CODES*4*DIGITS-1:0] CODES       = 48'h7248_0456_1233,
  parameter int                          MAX_FAIL    = 3,
  parameter int                          HOLD_CYCLES = 500,
  parameter int                          LOCK_CYCLES = 5000
) (
  input  logic clk,
  input  logic rst,
  keypad_code_lock_if.slave bus
);
  localparam int BW   = 4 * DIGITS;
  localparam int IW   = (N_CODES > 1) ? $clog2(N_CODES) : 1;
  localparam int CW   = $clog2(DIGITS + 1);
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int TMAX = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, ENTRY, RESULT, LOCKOUT} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [BW-1:0] disp_q, disp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fail_cnt_q, fail_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          match_q, match_d;
  logic          fail_q, fail_d;
  logic          locked_q, locked_d;

  logic          full;
  logic          hit;
  logic [IW-1:0] hit_idx;

  assign full = (cnt_q == CW'(DIGITS));

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = N_CODES - 1; k >= 0; k--) begin
      if (buf_q == CODES[k*BW +: BW]) begin
        hit     = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    match_d    = match_q;
    fail_d     = fail_q;
    locked_d   = locked_q;
    case (state_q)
      IDLE, ENTRY: begin
        if (bus.enter_valid) begin
          if (state_q == ENTRY) begin
            if (full && hit) begin
              match_d    = 1'b1;
              idx_d      = hit_idx;
              fail_cnt_d = '0;
              timer_d    = TW'(HOLD_CYCLES - 1);
              state_d    = RESULT;
            end else if (fail_cnt_q == FW'(MAX_FAIL - 1)) begin
              fail_cnt_d = FW'(MAX_FAIL);
              locked_d   = 1'b1;
              buf_d      = '0;
              cnt_d      = '0;
              timer_d    = TW'(LOCK_CYCLES - 1);
              state_d    = LOCKOUT;
            end else begin
              fail_cnt_d = fail_cnt_q + FW'(1);
              fail_d     = 1'b1;
              timer_d    = TW'(HOLD_CYCLES - 1);
              state_d    = RESULT;
            end
          end
        end else if (bus.key_valid) begin
          buf_d   = BW'({buf_q, bus.key_code});
          cnt_d   = full ? cnt_q : cnt_q + CW'(1);
          state_d = ENTRY;
        end
      end
      RESULT: begin
        if (timer_q == '0) begin
          match_d = 1'b0;
          fail_d  = 1'b0;
          idx_d   = '0;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      LOCKOUT: begin
        if (timer_q == '0) begin
          fail_cnt_d = '0;
          locked_d   = 1'b0;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    disp_d = (state_d == LOCKOUT) ? '1 : buf_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      disp_q     <= '0;
      cnt_q      <= '0;
      fail_cnt_q <= '0;
      timer_q    <= '0;
      idx_q      <= '0;
      match_q    <= 1'b0;
      fail_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      disp_q     <= disp_d;
      cnt_q      <= cnt_d;
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      match_q    <= match_d;
      fail_q     <= fail_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.disp      = disp_q;
  assign bus.match     = match_q;
  assign bus.match_idx = idx_q;
  assign bus.fail      = fail_q;
  assign bus.locked    = locked_q;
  assign bus.entry_cnt = cnt_q;
endmodule

// File: tb/tb_keypad_code_lock.sv
// Directed bench for keypad_code_lock: vector table for entry
// sequences plus hand-written hold, lockout and reset cases.
module tb_keypad_code_lock;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_code_lock_if #(.DIGITS(4), .N_CODES(3)) bus();

  keypad_code_lock dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        ev;
    logic [15:0] disp;
    logic [2:0]  cnt;
    logic        m;
    logic [1:0]  idx;
    logic        f;
    logic        l;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply(input logic kv, input logic [3:0] kc,
                       input logic ev);
    bus.key_valid   = kv;
    bus.key_code    = kc;
    bus.enter_valid = ev;
    tick();
    bus.key_valid   = 1'b0;
    bus.key_code    = 4'h0;
    bus.enter_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    apply(1'b1, k, 1'b0);
  endtask

  task automatic check_out(input string nm, input logic [15:0] d,
                           input logic [2:0] c, input logic m,
                           input logic [1:0] idx, input logic f,
                           input logic l);
    chk({nm, ".disp"}, 32'(bus.disp), 32'(d));
    chk({nm, ".cnt"}, 32'(bus.entry_cnt), 32'(c));
    chk({nm, ".match"}, 32'(bus.match), 32'(m));
    if (m) chk({nm, ".idx"}, 32'(bus.match_idx), 32'(idx));
    chk({nm, ".fail"}, 32'(bus.fail), 32'(f));
    chk({nm, ".locked"}, 32'(bus.locked), 32'(l));
  endtask

  // k = samples still expected high, counting the current one.
  task automatic finish_hold(input string nm, input int k,
                             input logic m, input logic f,
                             input logic l);
    repeat (k - 1) tick();
    chk({nm, ".last.match"}, 32'(bus.match), 32'(m));
    chk({nm, ".last.fail"}, 32'(bus.fail), 32'(f));
    chk({nm, ".last.locked"}, 32'(bus.locked), 32'(l));
    tick();
    check_out({nm, ".idle"}, 16'h0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      apply(tbl[i].kv, tbl[i].kc, tbl[i].ev);
      check_out($sformatf("vec%0d", i), tbl[i].disp, tbl[i].cnt,
                tbl[i].m, tbl[i].idx, tbl[i].f, tbl[i].l);
    end
  endtask

  task automatic enter4(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    apply(1'b0, 4'h0, 1'b1);
  endtask

  initial begin
    tbl[0]  = '{1, 4'h9, 0, 16'h0009, 3'd1, 0, 2'd0, 0, 0};
    tbl[1]  = '{1, 4'h7, 0, 16'h0097, 3'd2, 0, 2'd0, 0, 0};
    tbl[2]  = '{1, 4'h2, 0, 16'h0972, 3'd3, 0, 2'd0, 0, 0};
    tbl[3]  = '{1, 4'h4, 0, 16'h9724, 3'd4, 0, 2'd0, 0, 0};
    tbl[4]  = '{1, 4'h8, 0, 16'h7248, 3'd4, 0, 2'd0, 0, 0};
    tbl[5]  = '{0, 4'h0, 1, 16'h7248, 3'd4, 1, 2'd2, 0, 0};
    tbl[6]  = '{0, 4'h0, 1, 16'h0000, 3'd0, 0, 2'd0, 0, 0};
    tbl[7]  = '{1, 4'h0, 0, 16'h0000, 3'd1, 0, 2'd0, 0, 0};
    tbl[8]  = '{1, 4'h4, 0, 16'h0004, 3'd2, 0, 2'd0, 0, 0};
    tbl[9]  = '{1, 4'h5, 0, 16'h0045, 3'd3, 0, 2'd0, 0, 0};
    tbl[10] = '{1, 4'h6, 0, 16'h0456, 3'd4, 0, 2'd0, 0, 0};
    tbl[11] = '{1, 4'h5, 1, 16'h0456, 3'd4, 1, 2'd1, 0, 0};

    rst             = 1'b1;
    bus.key_valid   = 1'b0;
    bus.key_code    = 4'h0;
    bus.enter_valid = 1'b0;
    repeat (2) tick();
    check_out("reset", 16'h0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("reset.fail_cnt", 32'(dut.fail_cnt_q), 32'd0);
    rst = 1'b0;
    tick();

    run_vecs(0, 5);
    finish_hold("drop", 500, 1'b1, 1'b0, 1'b0);

    enter4(16'h1233);
    check_out("c0", 16'h1233, 3'd4, 1'b1, 2'd0, 1'b0, 1'b0);
    press(4'h5);
    check_out("c0.keyign", 16'h1233, 3'd4, 1'b1, 2'd0, 1'b0, 1'b0);
    finish_hold("c0", 499, 1'b1, 1'b0, 1'b0);

    press(4'h0);
    press(4'h4);
    press(4'h5);
    apply(1'b0, 4'h0, 1'b1);
    check_out("short", 16'h0045, 3'd3, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("short.fail_cnt", 32'(dut.fail_cnt_q), 32'd1);
    finish_hold("short", 500, 1'b0, 1'b1, 1'b0);
    enter4(16'h1233);
    check_out("retry", 16'h1233, 3'd4, 1'b1, 2'd0, 1'b0, 1'b0);
    chk("retry.fail_cnt", 32'(dut.fail_cnt_q), 32'd0);
    finish_hold("retry", 500, 1'b1, 1'b0, 1'b0);

    for (int n = 1; n <= 2; n++) begin
      enter4(16'h1111);
      check_out($sformatf("bad%0d", n), 16'h1111, 3'd4, 1'b0, 2'd0,
                1'b1, 1'b0);
      chk($sformatf("bad%0d.fail_cnt", n), 32'(dut.fail_cnt_q), 32'(n));
      finish_hold($sformatf("bad%0d", n), 500, 1'b0, 1'b1, 1'b0);
    end
    enter4(16'h1111);
    check_out("lock", 16'hFFFF, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    press(4'h7);
    check_out("lock.keyign", 16'hFFFF, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    finish_hold("lock", 4999, 1'b0, 1'b0, 1'b1);
    chk("unlock.fail_cnt", 32'(dut.fail_cnt_q), 32'd0);

    run_vecs(6, 11);
    finish_hold("same", 500, 1'b1, 1'b0, 1'b0);

    press(4'h1);
    press(4'h2);
    check_out("pre_rst", 16'h0012, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_out("async_rst", 16'h0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_out("post_rst", 16'h0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("post_rst.state", 32'(dut.state_q), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
